// File: rtl/ariane_pkg.sv
// ariane_pkg: shared types for the renaming map slice
// Provides register-count constants, the scoreboard entry and the issue wrapper
// {valid, sbe} exchanged between decode and issue.
package ariane_pkg;
   localparam int NR_ARCH_REGS  = 32;
   localparam int NR_PHYS_REGS  = 64;
   localparam int REG_ADDR_SIZE = 6;
   typedef enum logic [2:0] {NONE, LOAD, STORE, ALU, CTRL_FLOW, MULT, CSR} fu_t;
   typedef struct packed {
      logic [31:0]              pc;
      logic [7:0]               trans_id;
      fu_t                      fu;
      logic [7:0]               op;
      logic [REG_ADDR_SIZE-1:0] rs1;
      logic [REG_ADDR_SIZE-1:0] rs2;
      logic [REG_ADDR_SIZE-1:0] rd;
      logic [63:0]              result;
      logic                     use_imm;
   } scoreboard_entry_t;
   typedef struct packed {
      logic              valid;
      scoreboard_entry_t sbe;
   } issue_struct_t;
endpackage

// File: rtl/cva6_renaming_map_free_list.sv
// cva6_renaming_map_free_list: physical register free bitmap with find-first-free
// Ports: clk/rst (async active-high), alloc consumes alloc_idx on the edge,
// rel_en/rel_idx returns a register, alloc_idx is the lowest free index,
// empty flags no free register.
module cva6_renaming_map_free_list #(
   parameter int unsigned W  = 6,
   parameter int unsigned NR = 64,
   parameter int unsigned NA = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         alloc,
   input  logic         rel_en,
   input  logic [W-1:0] rel_idx,
   output logic [W-1:0] alloc_idx,
   output logic         empty
);
   logic [NR-1:0] free_q;
   // Scanning downward leaves the lowest set bit as the final assignment.
   always_comb begin
      alloc_idx = '0;
      for (int i = NR - 1; i >= 0; i--) if (free_q[i]) alloc_idx = W'(i);
   end
   assign empty = ~|free_q;
   // Allocation and release land on the same edge; the allocated index was free,
   // so it can never collide with a register being released.
   always_ff @(posedge clk or posedge rst)
      if (rst) free_q <= {{(NR-NA){1'b1}}, {NA{1'b0}}};
      else     free_q <= (free_q & ~(NR'(alloc) << alloc_idx)) | (NR'(rel_en) << rel_idx);
endmodule

// File: rtl/cva6_renaming_map.sv
// cva6_renaming_map: renames rd/rs1/rs2 of issued entries from architectural to physical registers
// Ports: clk_i, rst_ni (async, active-high), fetch_entry_ready_i (issue accepts issue_n),
// issue_n (un-renamed entry), issue_q (registered renamed entry), waddr_i/we_gp_i
// (physical destination of the committing GP write).
module cva6_renaming_map
   import ariane_pkg::*;
#(
   parameter int unsigned ARCH_REG_WIDTH = 5,
   parameter int unsigned PHYS_REG_WIDTH = 6
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   input  logic                      fetch_entry_ready_i,
   input  issue_struct_t             issue_n,
   output issue_struct_t             issue_q,
   input  logic [PHYS_REG_WIDTH-1:0] waddr_i,
   input  logic                      we_gp_i
);
   logic [PHYS_REG_WIDTH-1:0] map_q  [2**ARCH_REG_WIDTH];
   logic [PHYS_REG_WIDTH-1:0] prev_q [2**PHYS_REG_WIDTH];
   logic [ARCH_REG_WIDTH-1:0] rd_a, rs1_a, rs2_a;
   logic [PHYS_REG_WIDTH-1:0] alloc_idx, rel_idx;
   logic accept, need, empty, do_alloc, rel_en;
   issue_struct_t issue_d;
   assign rd_a     = issue_n.sbe.rd[ARCH_REG_WIDTH-1:0];
   assign rs1_a    = issue_n.sbe.rs1[ARCH_REG_WIDTH-1:0];
   assign rs2_a    = issue_n.sbe.rs2[ARCH_REG_WIDTH-1:0];
   assign accept   = fetch_entry_ready_i & issue_n.valid;
   assign need     = accept & (rd_a != '0);
   assign do_alloc = need & ~empty;
   // Committing register retires the mapping it replaced; p0 is pinned to x0 and never returned.
   assign rel_idx  = prev_q[waddr_i];
   assign rel_en   = we_gp_i & (waddr_i != '0) & (rel_idx != '0);
   cva6_renaming_map_free_list #(
      .W (PHYS_REG_WIDTH),
      .NR(2**PHYS_REG_WIDTH),
      .NA(2**ARCH_REG_WIDTH)
   ) i_free_list (
      .clk      (clk_i),
      .rst      (rst_ni),
      .alloc    (do_alloc),
      .rel_en   (rel_en),
      .rel_idx  (rel_idx),
      .alloc_idx(alloc_idx),
      .empty    (empty)
   );
   // Sources read the pre-update map, so rs==rd sees the older physical register.
   always_comb begin
      issue_d = issue_q;
      if (fetch_entry_ready_i) begin
         issue_d = issue_n;
         if (issue_n.valid) begin
            issue_d.sbe.rs1 = REG_ADDR_SIZE'(map_q[rs1_a]);
            issue_d.sbe.rs2 = REG_ADDR_SIZE'(map_q[rs2_a]);
            issue_d.sbe.rd  = (rd_a == '0) ? '0 : REG_ADDR_SIZE'(alloc_idx);
            issue_d.valid   = ~(need & empty);
         end
      end
   end
   always_ff @(posedge clk_i or posedge rst_ni)
      if (rst_ni) begin
         issue_q <= '0;
         for (int a = 0; a < 2**ARCH_REG_WIDTH; a++) map_q[a] <= PHYS_REG_WIDTH'(a);
         for (int p = 0; p < 2**PHYS_REG_WIDTH; p++) prev_q[p] <= '0;
      end else begin
         issue_q <= issue_d;
         if (do_alloc) begin
            map_q[rd_a]       <= alloc_idx;
            prev_q[alloc_idx] <= map_q[rd_a];
         end
      end
   // Scoreboard depth keeps outstanding renames well below the free pool.
   no_free_reg: assert property (@(posedge clk_i) disable iff (rst_ni) !(need && empty));
endmodule

// File: tb/tb_cva6_renaming_map.sv
// tb_cva6_renaming_map: directed self-checking bench for the renaming map
module tb_cva6_renaming_map;
   import ariane_pkg::*;
   logic clk_i = 1'b0;
   logic rst_ni = 1'b1;
   logic fetch_entry_ready_i = 1'b0;
   logic we_gp_i = 1'b0;
   logic [5:0] waddr_i = '0;
   issue_struct_t issue_n = '0;
   issue_struct_t issue_q;
   int pass_cnt = 0;
   int total = 0;
   logic [18:0] got, exp_v;
   always #5 clk_i = ~clk_i;
   cva6_renaming_map dut (
      .clk_i              (clk_i),
      .rst_ni             (rst_ni),
      .fetch_entry_ready_i(fetch_entry_ready_i),
      .issue_n            (issue_n),
      .issue_q            (issue_q),
      .waddr_i            (waddr_i),
      .we_gp_i            (we_gp_i)
   );
   function automatic issue_struct_t ent(input logic v, input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
      issue_struct_t e;
      e = '0;
      e.valid = v;
      e.sbe.pc = 32'h8000_0000 | 32'(rd);
      e.sbe.fu = ALU;
      e.sbe.op = 8'h33;
      e.sbe.rd = {1'b0, rd};
      e.sbe.rs1 = {1'b0, rs1};
      e.sbe.rs2 = {1'b0, rs2};
      e.sbe.result = 64'hdead_beef_0000_0000 | 64'(rs1);
      return e;
   endfunction
   function automatic logic [18:0] obs();
      return {issue_q.valid, issue_q.sbe.rd, issue_q.sbe.rs1, issue_q.sbe.rs2};
   endfunction
   function automatic logic [18:0] tri_v(input logic v, input int rd, input int rs1, input int rs2);
      return {v, 6'(rd), 6'(rs1), 6'(rs2)};
   endfunction
   task automatic cyc(input logic rdy, input issue_struct_t e, input logic we, input logic [5:0] wa);
      fetch_entry_ready_i = rdy;
      issue_n = e;
      we_gp_i = we;
      waddr_i = wa;
      @(posedge clk_i);
      #1;
      fetch_entry_ready_i = 1'b0;
      we_gp_i = 1'b0;
   endtask
   task automatic do_reset();
      rst_ni = 1'b1;
      @(posedge clk_i);
      #1;
      rst_ni = 1'b0;
   endtask
   task automatic test_reset();
      do_reset();
      cyc(0, ent(0, 0, 0, 0), 0, 0);
      cyc(0, ent(0, 0, 0, 0), 0, 0);
      got = obs(); total++;
      if (got !== 19'd0 || issue_q !== '0) $display("FAIL reset_state: got %h exp %h", got, 19'd0); else pass_cnt++;
   endtask
   task automatic test_rename();
      do_reset();
      cyc(1, ent(1, 5, 1, 2), 0, 0);
      got = obs(); exp_v = tri_v(1, 32, 1, 2); total++;
      if (got !== exp_v) $display("FAIL add_x5: got %h exp %h", got, exp_v); else pass_cnt++;
      total++;
      if (issue_q.sbe.pc !== 32'h8000_0005 || issue_q.sbe.result !== 64'hdead_beef_0000_0001 || issue_q.sbe.fu !== ALU)
         $display("FAIL passthrough: got pc %h result %h exp pc 80000005 result deadbeef00000001", issue_q.sbe.pc, issue_q.sbe.result);
      else pass_cnt++;
      cyc(1, ent(1, 6, 5, 5), 0, 0);
      got = obs(); exp_v = tri_v(1, 33, 32, 32); total++;
      if (got !== exp_v) $display("FAIL add_x6: got %h exp %h", got, exp_v); else pass_cnt++;
   endtask
   task automatic test_x0();
      do_reset();
      cyc(1, ent(1, 0, 3, 0), 0, 0);
      got = obs(); exp_v = tri_v(1, 0, 3, 0); total++;
      if (got !== exp_v) $display("FAIL rd_x0: got %h exp %h", got, exp_v); else pass_cnt++;
      cyc(1, ent(1, 7, 0, 0), 0, 0);
      got = obs(); exp_v = tri_v(1, 32, 0, 0); total++;
      if (got !== exp_v) $display("FAIL after_x0_alloc: got %h exp %h", got, exp_v); else pass_cnt++;
   endtask
   task automatic test_idle_and_hold();
      cyc(1, ent(0, 9, 10, 11), 0, 0);
      got = obs(); exp_v = tri_v(0, 9, 10, 11); total++;
      if (got !== exp_v) $display("FAIL invalid_pass: got %h exp %h", got, exp_v); else pass_cnt++;
      cyc(1, ent(1, 8, 7, 0), 0, 0);
      got = obs(); exp_v = tri_v(1, 33, 32, 0); total++;
      if (got !== exp_v) $display("FAIL after_invalid: got %h exp %h", got, exp_v); else pass_cnt++;
      cyc(0, ent(1, 9, 1, 1), 0, 0);
      cyc(0, ent(1, 9, 1, 1), 0, 0);
      got = obs(); total++;
      if (got !== exp_v) $display("FAIL ready_low_hold: got %h exp %h", got, exp_v); else pass_cnt++;
      cyc(1, ent(1, 10, 8, 7), 0, 0);
      got = obs(); exp_v = tri_v(1, 34, 33, 32); total++;
      if (got !== exp_v) $display("FAIL after_hold: got %h exp %h", got, exp_v); else pass_cnt++;
   endtask
   task automatic test_commit_free();
      do_reset();
      cyc(1, ent(1, 5, 5, 0), 0, 0);
      got = obs(); exp_v = tri_v(1, 32, 5, 0); total++;
      if (got !== exp_v) $display("FAIL x5_first: got %h exp %h", got, exp_v); else pass_cnt++;
      cyc(1, ent(1, 5, 5, 0), 0, 0);
      got = obs(); exp_v = tri_v(1, 33, 32, 0); total++;
      if (got !== exp_v) $display("FAIL x5_second: got %h exp %h", got, exp_v); else pass_cnt++;
      cyc(0, ent(0, 0, 0, 0), 1, 32);
      cyc(1, ent(1, 6, 5, 0), 0, 0);
      got = obs(); exp_v = tri_v(1, 5, 33, 0); total++;
      if (got !== exp_v) $display("FAIL realloc_p5: got %h exp %h", got, exp_v); else pass_cnt++;
      cyc(0, ent(0, 0, 0, 0), 1, 33);
      cyc(1, ent(1, 7, 6, 0), 0, 0);
      got = obs(); exp_v = tri_v(1, 32, 5, 0); total++;
      if (got !== exp_v) $display("FAIL realloc_p32: got %h exp %h", got, exp_v); else pass_cnt++;
      cyc(0, ent(0, 0, 0, 0), 1, 0);
      cyc(1, ent(1, 8, 0, 0), 0, 0);
      got = obs(); exp_v = tri_v(1, 34, 0, 0); total++;
      if (got !== exp_v) $display("FAIL waddr0_ignored: got %h exp %h", got, exp_v); else pass_cnt++;
      cyc(0, ent(0, 0, 0, 0), 1, 1);
      cyc(1, ent(1, 9, 0, 0), 0, 0);
      got = obs(); exp_v = tri_v(1, 35, 0, 0); total++;
      if (got !== exp_v) $display("FAIL p0_never_freed: got %h exp %h", got, exp_v); else pass_cnt++;
   endtask
   task automatic test_same_cycle();
      do_reset();
      cyc(1, ent(1, 7, 0, 0), 0, 0);
      got = obs(); exp_v = tri_v(1, 32, 0, 0); total++;
      if (got !== exp_v) $display("FAIL sc_x7: got %h exp %h", got, exp_v); else pass_cnt++;
      cyc(1, ent(1, 8, 7, 0), 1, 32);
      got = obs(); exp_v = tri_v(1, 33, 32, 0); total++;
      if (got !== exp_v) $display("FAIL sc_pre_edge_list: got %h exp %h", got, exp_v); else pass_cnt++;
      cyc(1, ent(1, 9, 8, 7), 0, 0);
      got = obs(); exp_v = tri_v(1, 7, 33, 32); total++;
      if (got !== exp_v) $display("FAIL sc_freed_next: got %h exp %h", got, exp_v); else pass_cnt++;
   endtask
   task automatic test_async_reset();
      do_reset();
      cyc(1, ent(1, 5, 1, 2), 0, 0);
      cyc(1, ent(1, 6, 5, 5), 0, 0);
      got = obs(); exp_v = tri_v(1, 33, 32, 32); total++;
      if (got !== exp_v) $display("FAIL pre_reset: got %h exp %h", got, exp_v); else pass_cnt++;
      #2;
      rst_ni = 1'b1;
      #1;
      got = obs(); total++;
      if (got !== 19'd0) $display("FAIL async_clear: got %h exp %h", got, 19'd0); else pass_cnt++;
      rst_ni = 1'b0;
      cyc(1, ent(1, 9, 5, 6), 0, 0);
      got = obs(); exp_v = tri_v(1, 32, 5, 6); total++;
      if (got !== exp_v) $display("FAIL map_identity: got %h exp %h", got, exp_v); else pass_cnt++;
   endtask
   initial begin
      test_reset();
      test_rename();
      test_x0();
      test_idle_and_hold();
      test_commit_free();
      test_same_cycle();
      test_async_reset();
      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end
endmodule
